instr_mem_loadable: RTL and testbench

INSTR_MEM_LOADABLE -- requirements
Module: instr_mem_loadable

---
 rtl/instr_mem_loadable.sv | 136 +++++++++++++
 tb/tb_instr_mem_loadable.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory with a one-deep registered fetch response.
// After reset an init sweep fills every word with NOP_WORD, one word per cycle.
// Once the sweep is done the memory accepts program-load writes and fetch requests.
// A load always takes precedence over a fetch that arrives in the same cycle.
module instr_mem_loadable #(
    parameter int unsigned DEPTH    = 64,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_inst,
    output logic [1:0]  rsp_fault,
    input  logic        flush,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        load_err,
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [1:0] FAULT_OK    = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE = 2'b10;

    typedef enum logic {
        S_INIT,
        S_READY
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] init_idx;
    logic [AW-1:0] init_idx_next;

    logic [31:0]   mem [DEPTH];

    logic          req_fire;
    logic          load_fire;
    logic [1:0]    req_flt;
    logic [1:0]    load_flt;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] load_idx;

    // A misaligned address is reported before an out-of-range one. The whole
    // word address is compared against DEPTH, so a high address can never
    // alias into the array.
    function automatic logic [1:0] fault_of(input logic [31:0] a);
        if (a[1:0] != 2'b00)
            return FAULT_ALIGN;
        else if (a[31:2] >= 30'(DEPTH))
            return FAULT_RANGE;
        else
            return FAULT_OK;
    endfunction

    assign req_flt   = fault_of(req_addr);
    assign load_flt  = fault_of(load_addr);
    assign req_idx   = req_addr[AW+1:2];
    assign load_idx  = load_addr[AW+1:2];
    assign req_fire  = req_valid & req_ready;
    assign load_fire = load_valid & load_ready;

    // State and sweep-index register; reset restarts the init sweep from word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_INIT;
            init_idx <= '0;
        end else begin
            state    <= state_next;
            init_idx <= init_idx_next;
        end
    end

    // Next-state logic plus the handshake outputs that depend on the state.
    always_comb begin
        state_next    = state;
        init_idx_next = init_idx;
        busy          = 1'b0;
        req_ready     = 1'b0;
        load_ready    = 1'b0;
        case (state)
            S_INIT: begin
                busy          = 1'b1;
                init_idx_next = init_idx + 1'b1;
                if (init_idx == AW'(DEPTH - 1))
                    state_next = S_READY;
            end
            S_READY: begin
                load_ready = 1'b1;
                req_ready  = ~load_valid & ~flush & (~rsp_valid | rsp_ready);
            end
            default: state_next = S_INIT;
        endcase
    end

    // The storage has a single write port. The init sweep uses it while busy,
    // and accepted non-faulting loads use it once the sweep is done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_INIT)
                mem[init_idx] <= NOP_WORD;
            else if (load_fire && load_flt == FAULT_OK)
                mem[load_idx] <= load_data;
        end
    end

    // Response register and load-error pulse.
    // An accepted fetch overrides both the flush clear and the consume clear.
    // Flush and acceptance can never coincide, because flush forces req_ready low.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_inst  <= NOP_WORD;
            rsp_fault <= FAULT_OK;
            load_err  <= 1'b0;
        end else begin
            load_err <= load_fire & (load_flt != FAULT_OK);
            if (req_fire) begin
                rsp_valid <= 1'b1;
                rsp_fault <= req_flt;
                rsp_inst  <= (req_flt == FAULT_OK) ? mem[req_idx] : NOP_WORD;
            end else if (flush || rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed self-checking bench for instr_mem_loadable with DEPTH = 64.
// Inputs are driven and outputs are sampled 1 ns after each rising edge.
module tb_instr_mem_loadable;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_inst;
    logic [1:0]  rsp_fault;
    logic        flush;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        load_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    instr_mem_loadable #(.DEPTH(64), .NOP_WORD(32'h0000_0013)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_inst(rsp_inst), .rsp_fault(rsp_fault),
        .flush(flush),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_addr(load_addr), .load_data(load_data),
        .load_err(load_err), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset for one edge, then counts busy cycles (bounded) and checks the count.
    task automatic reset_and_wait(input string name);
        int n;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 64) begin
            errors++;
            $display("FAIL %s_busy_cycles: got %0d expected 64", name, n);
        end
    endtask

    // Drives one fetch and checks the registered response one cycle later.
    task automatic fetch_check(input string name, input logic [31:0] addr,
                               input logic [31:0] exp_inst, input logic [1:0] exp_fault);
        req_valid = 1'b1;
        req_addr  = addr;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_req_ready: got %b expected 1", name, req_ready);
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_inst !== exp_inst || rsp_fault !== exp_fault) begin
            errors++;
            $display("FAIL %s_rsp: got v=%b inst=%h fault=%b expected v=1 inst=%h fault=%b",
                     name, rsp_valid, rsp_inst, rsp_fault, exp_inst, exp_fault);
        end
        tick();
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [31:0] data);
        load_valid = 1'b1;
        load_addr  = addr;
        load_data  = data;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0 || load_ready !== 1'b0 || rsp_valid !== 1'b0 ||
            rsp_inst !== NOP || rsp_fault !== 2'b00 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b rr=%b lr=%b v=%b inst=%h f=%b le=%b expected 1 0 0 0 %h 00 0",
                     busy, req_ready, load_ready, rsp_valid, rsp_inst, rsp_fault, load_err, NOP);
        end
        // A pending load/fetch during the sweep must stay unaccepted.
        req_valid  = 1'b1;
        load_valid = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL init_ready_low: got rr=%b lr=%b expected 0 0", req_ready, load_ready);
        end
        req_valid  = 1'b0;
        load_valid = 1'b0;
        reset_and_wait("reset");
        checks++;
        if (busy !== 1'b0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_state: got busy=%b lr=%b expected 0 1", busy, load_ready);
        end
        fetch_check("fetch0", 32'h0, NOP, 2'b00);
    endtask

    task automatic test_load_fetch();
        load_valid = 1'b1;
        load_addr  = 32'h08;
        load_data  = 32'h0050_0093;
        tick();
        load_valid = 1'b0;
        checks++;
        if (load_err !== 1'b0) begin
            errors++;
            $display("FAIL good_load_err: got %b expected 0", load_err);
        end
        fetch_check("load_fetch", 32'h08, 32'h0050_0093, 2'b00);
    endtask

    task automatic test_faults();
        fetch_check("misaligned", 32'h06, NOP, 2'b01);
        fetch_check("out_of_range", 32'h100, NOP, 2'b10);
        fetch_check("both_faults", 32'h102, NOP, 2'b01);
        do_load(32'h102, 32'hDEAD_BEEF);
        checks++;
        if (load_err !== 1'b1) begin
            errors++;
            $display("FAIL load_err_pulse: got %b expected 1", load_err);
        end
        tick();
        checks++;
        if (load_err !== 1'b0) begin
            errors++;
            $display("FAIL load_err_one_cycle: got %b expected 0", load_err);
        end
        // Word index 65 would alias to word 1 if the address wrapped.
        do_load(32'h104, 32'hBAD0_0001);
        checks++;
        if (load_err !== 1'b1) begin
            errors++;
            $display("FAIL load_err_range: got %b expected 1", load_err);
        end
        fetch_check("no_alias", 32'h04, NOP, 2'b00);
        fetch_check("word0_intact", 32'h00, NOP, 2'b00);
        fetch_check("word2_intact", 32'h08, 32'h0050_0093, 2'b00);
    endtask

    task automatic test_backpressure();
        do_load(32'h04, 32'h1111_1111);
        do_load(32'h0C, 32'h3333_3333);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h04;
        tick();
        req_addr = 32'h08;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_inst !== 32'h1111_1111) begin
                errors++;
                $display("FAIL stall_%0d: got rr=%b v=%b inst=%h expected rr=0 v=1 inst=11111111",
                         i, req_ready, rsp_valid, rsp_inst);
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL resume_ready: got %b expected 1", req_ready);
        end
        tick();
        req_addr = 32'h0C;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_inst !== 32'h0050_0093) begin
            errors++;
            $display("FAIL b2b_1: got v=%b inst=%h expected v=1 inst=00500093", rsp_valid, rsp_inst);
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_inst !== 32'h3333_3333) begin
            errors++;
            $display("FAIL b2b_2: got v=%b inst=%h expected v=1 inst=33333333", rsp_valid, rsp_inst);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: got v=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_load_priority();
        load_valid = 1'b1;
        load_addr  = 32'h14;
        load_data  = 32'hCAFE_F00D;
        req_valid  = 1'b1;
        req_addr   = 32'h14;
        rsp_ready  = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_priority: got rr=%b lr=%b expected 0 1", req_ready, load_ready);
        end
        tick();
        load_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_stalled: got v=%b expected 0", rsp_valid);
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_inst !== 32'hCAFE_F00D || rsp_fault !== 2'b00) begin
            errors++;
            $display("FAIL after_load: got v=%b inst=%h f=%b expected v=1 inst=cafef00d f=00",
                     rsp_valid, rsp_inst, rsp_fault);
        end
        tick();
    endtask

    task automatic test_flush();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h04;
        tick();
        req_addr   = 32'h08;
        flush      = 1'b1;
        load_valid = 1'b1;
        load_addr  = 32'h18;
        load_data  = 32'h0A0B_0C0D;
        #1;
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup: got rr=%b v=%b expected 0 1", req_ready, rsp_valid);
        end
        tick();
        flush      = 1'b0;
        load_valid = 1'b0;
        req_valid  = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: got v=%b expected 0", rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_rsp: got v=%b expected 0", rsp_valid);
        end
        fetch_check("load_during_flush", 32'h18, 32'h0A0B_0C0D, 2'b00);
    endtask

    task automatic test_reset_mid_init();
        // Leave a valid response behind so that reset has to clear it.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h08;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_inst !== NOP) begin
            errors++;
            $display("FAIL reset_clears_rsp: got v=%b inst=%h expected v=0 inst=%h", rsp_valid, rsp_inst, NOP);
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_init_busy: got %b expected 1", busy);
        end
        reset_and_wait("mid_init");
        fetch_check("wiped_08", 32'h08, NOP, 2'b00);
        fetch_check("wiped_14", 32'h14, NOP, 2'b00);
        fetch_check("wiped_18", 32'h18, NOP, 2'b00);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        rsp_ready  = 1'b1;
        flush      = 1'b0;
        load_valid = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        #1;
        test_reset();
        test_load_fetch();
        test_faults();
        test_backpressure();
        test_load_priority();
        test_flush();
        test_reset_mid_init();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
